sync_fifo_wr_ctrl: RTL and testbench
====================================

// Module: sync_fifo_wr_ctrl
// PURPOSE
//   Write-side controller of the synchronous FIFO.
//   - Accepts push requests, gates them against full, and drives the FIFO RAM write port (enable, address, data).
//   - Tracks occupancy from its own accepted writes and from ram_rd_en pops issued by the read side.
//   - Returns a registered write acknowledge one cycle after each accepted write, plus full, sticky-overflow and optional almost-full status.
// PARAMETERS
//   DW         8    data width, bits
//   AW         3    RAM address width; DEPTH = 2**AW entries
//   AFULL_LVL  6    almost_full threshold in entries, 1..DEPTH (used only with SYNC_FIFO_AFULL_EN)
// PORTS
//   clk          in   1     clock, all state updates on rising edge
//   rst          in   1     asynchronous reset, active-high
//   wr_en        in   1     push request, qualified every cycle
//   wr_data      in   DW    push data, valid with wr_en
//   ram_rd_en    in   1     pop from read side; one entry leaves the FIFO this cycle
//   ovf_clr      in   1     clear sticky overflow
//   ram_wr_en    out  1     RAM write strobe (combinational)
//   ram_wr_addr  out  AW    RAM write address = wr_ptr
//   ram_wr_data  out  DW    RAM write data = wr_data
//   wr_ack       out  1     registered; 1 for one cycle after an accepted write
//   full         out  1     registered; wr_count == DEPTH
//   wr_count     out  AW+1  registered occupancy, 0..DEPTH
//   overflow     out  1     registered sticky; push attempted while full
//   almost_full  out  1     registered; present only with SYNC_FIFO_AFULL_EN
// BEHAVIOUR
//   - Reset (async, rst=1): wr_ptr=0, wr_count=0, full=0, wr_ack=0, overflow=0, almost_full=0.
//     Takes effect immediately, including mid-burst. RAM contents are not cleared.
//   - accept = wr_en & ~full. ram_wr_en = accept, same cycle; the RAM captures on that clk edge.
//     ram_wr_addr = wr_ptr, ram_wr_data = wr_data, both combinational.
//   - wr_ptr += 1 on accept; wraps from DEPTH-1 to 0 (natural AW-bit wrap).
//   - pop = ram_rd_en & (wr_count != 0). ram_rd_en while empty is ignored, with no underflow of wr_count.
//   - wr_count next value:
//     - accept only: +1
//     - pop only: -1
//     - accept and pop together: unchanged
//     - neither: unchanged
//   - full and almost_full are computed from next wr_count and registered, so they are valid the cycle after the update.
//   - Full with wr_en=1 and ram_rd_en=1 together:
//     - the write is rejected (ram_wr_en=0) and counts as an overflow;
//     - the pop decrements wr_count, so full=0 next cycle.
//   - Latency: accept in cycle N gives wr_ack=1 in cycle N+1. Back-to-back accepts hold wr_ack high continuously.
//   - overflow: set on wr_en & full; cleared by ovf_clr. When both occur in the same cycle, set wins.
//   - No state machine. State is wr_ptr, wr_count, flag registers and wr_ack.
// CONFIGURATION
//   - SYNC_FIFO_AFULL_EN defined:
//     - almost_full port exists;
//     - almost_full = (next wr_count >= AFULL_LVL), registered, reset 0.
//   - Not defined: almost_full port and its logic are absent; all other behaviour is identical.
// TESTING (DW=8, AW=3, DEPTH=8, AFULL_LVL=6)
//   1. Reset, then 8 pushes 0x10..0x17 with no pops:
//      - ram_wr_addr runs 0..7;
//      - wr_ack=1 from cycle 2 to cycle 9;
//      - wr_count ends at 8, full=1;
//      - almost_full=1 from the cycle after the 6th push (macro on).
//   2. While full, wr_en=1 for 2 cycles with no pop:
//      - ram_wr_en=0, wr_count stays 8;
//      - overflow=1 and stays set;
//      - ovf_clr pulse gives overflow=0 next cycle.
//   3. While full, wr_en=1 and ram_rd_en=1 in the same cycle:
//      - no write;
//      - wr_count goes to 7, full=0 next cycle;
//      - overflow=1.
//   4. From count 4, 5 cycles of simultaneous wr_en and ram_rd_en: wr_count holds 4, 5 writes occur, wr_ptr wraps 7->0.
//   5. Empty FIFO, ram_rd_en=1 for 3 cycles: wr_count stays 0, full=0, no other output changes.
//   6. Assert rst mid-burst at count 5:
//      - all outputs 0 immediately, wr_ptr=0;
//      - the first push after release writes address 0.

Source files
------------

// File: rtl/sync_fifo_wr_ctrl.sv
// Write-side controller of a synchronous FIFO: push gating, RAM write port, occupancy and status flags.
// Define SYNC_FIFO_AFULL_EN to add the registered almost_full output.
module sync_fifo_wr_ctrl #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 3,
    parameter int unsigned AFULL_LVL = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          ram_rd_en,
    input  logic          ovf_clr,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic          wr_ack,
    output logic          full,
    output logic [AW:0]   wr_count,
    output logic          overflow
`ifdef SYNC_FIFO_AFULL_EN
    ,
    output logic          almost_full
`endif
);

    localparam logic [AW:0] LP_DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_wr_count;
    logic          r_full;
    logic          r_wr_ack;
    logic          r_overflow;
    logic          w_accept;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    assign w_accept = wr_en & ~r_full;
    assign w_pop    = ram_rd_en & (r_wr_count != '0);

    // Simultaneous accept and pop cancel out, so occupancy only moves on one-sided traffic.
    always_comb begin
        w_count_nxt = r_wr_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_wr_count + LP_ONE;
            2'b01:   w_count_nxt = r_wr_count - LP_ONE;
            default: w_count_nxt = r_wr_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
            r_full     <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_wr_count <= w_count_nxt;
            r_full     <= (w_count_nxt == LP_DEPTH);
            r_wr_ack   <= w_accept;
            // A fresh overflow takes priority over a clear in the same cycle.
            if (wr_en & r_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_AFULL_EN
    localparam logic [AW:0] LP_AFULL = (AW+1)'(AFULL_LVL);

    logic r_almost_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_nxt >= LP_AFULL);
        end
    end

    assign almost_full = r_almost_full;
`endif

    assign ram_wr_en   = w_accept;
    assign ram_wr_addr = r_wr_ptr;
    assign ram_wr_data = wr_data;
    assign wr_ack      = r_wr_ack;
    assign full        = r_full;
    assign wr_count    = r_wr_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_sync_fifo_wr_ctrl.sv
// Self-checking bench for sync_fifo_wr_ctrl: directed scenarios plus random traffic against an occupancy model.
module tb_sync_fifo_wr_ctrl;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ram_rd_en;
    logic       ovf_clr;
    logic       ram_wr_en;
    logic [2:0] ram_wr_addr;
    logic [7:0] ram_wr_data;
    logic       wr_ack;
    logic       full;
    logic [3:0] wr_count;
    logic       overflow;
`ifdef SYNC_FIFO_AFULL_EN
    logic       almost_full;
`endif

    sync_fifo_wr_ctrl #(.DW(8), .AW(3), .AFULL_LVL(6)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .ram_rd_en(ram_rd_en), .ovf_clr(ovf_clr),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .wr_ack(wr_ack), .full(full), .wr_count(wr_count), .overflow(overflow)
`ifdef SYNC_FIFO_AFULL_EN
        , .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy as an integer, write address as total accepted writes mod DEPTH.
    int m_count;
    int m_writes;
    bit m_ovf;
    bit m_ack;
    bit m_afull;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_writes = 0;
        m_ovf    = 0;
        m_ack    = 0;
        m_afull  = 0;
    endtask

    task automatic check_regs();
        chk("wr_ack",   32'(wr_ack),   32'(m_ack));
        chk("full",     32'(full),     32'(m_count == DEPTH));
        chk("wr_count", 32'(wr_count), 32'(m_count));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SYNC_FIFO_AFULL_EN
        chk("almost_full", 32'(almost_full), 32'(m_afull));
`endif
    endtask

    // One clock: drive inputs, check write port before the edge, then registered state after it.
    task automatic cycle(input bit we, input logic [7:0] wd, input bit rd, input bit clr);
        bit acc;
        bit pop;
        bit was_full;
        wr_en = we; wr_data = wd; ram_rd_en = rd; ovf_clr = clr;
        #1;
        was_full = (m_count == DEPTH);
        acc = we && !was_full;
        pop = rd && (m_count > 0);
        chk("ram_wr_en",   32'(ram_wr_en),   32'(acc));
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(m_writes % DEPTH));
        chk("ram_wr_data", 32'(ram_wr_data), 32'(wd));
        m_count  = m_count + int'(acc) - int'(pop);
        m_writes = m_writes + int'(acc);
        if (we && was_full) m_ovf = 1;
        else if (clr)       m_ovf = 0;
        m_ack   = acc;
        m_afull = (m_count >= AFULL);
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        wr_en = 0; ram_rd_en = 0; ovf_clr = 0; wr_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_regs();
        chk("reset_addr", 32'(ram_wr_addr), 32'd0);
    endtask

    initial begin
        rst = 1'b0; wr_en = 0; wr_data = '0; ram_rd_en = 0; ovf_clr = 0;
        model_reset();
        @(posedge clk);
        #1;
        sync_reset();

        // 1: fill with 0x10..0x17
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h10 + i), 0, 0);
        chk("fill_count", 32'(wr_count), 32'd8);
        chk("fill_full",  32'(full),     32'd1);

        // 2: push while full, then clear overflow
        cycle(1, 8'hAA, 0, 0);
        cycle(1, 8'hAB, 0, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        cycle(0, 8'h00, 0, 1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // set wins over clear in the same cycle
        cycle(1, 8'hAC, 0, 1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        cycle(0, 8'h00, 0, 1);

        // 3: full with push and pop together
        cycle(1, 8'hBB, 1, 0);
        chk("fullpop_count", 32'(wr_count), 32'd7);
        chk("fullpop_full",  32'(full),     32'd0);
        chk("fullpop_ovf",   32'(overflow), 32'd1);

        // 4: from count 4 with pointer at 6, five push+pop cycles wrap the pointer
        sync_reset();
        for (int i = 0; i < 6; i++) cycle(1, 8'(8'h20 + i), 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("pp_start", 32'(wr_count), 32'd4);
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h30 + i), 1, 0);
        chk("pp_hold", 32'(wr_count), 32'd4);
        chk("pp_wrap", 32'(ram_wr_addr), 32'd3);

        // 5: pops while empty
        sync_reset();
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
        chk("empty_pop", 32'(wr_count), 32'd0);

        // 6: asynchronous reset mid-burst at count 5
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h40 + i), 0, 0);
        wr_en = 1; wr_data = 8'h55;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        chk("async_addr", 32'(ram_wr_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 8'h66, 0, 0);
        chk("post_reset_ack", 32'(wr_ack), 32'd1);

        // random traffic, with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                sync_reset();
            end else begin
                cycle(bit'($urandom_range(0, 99) < 60), 8'($urandom),
                      bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 10));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
